// File: rtl/data_packer.sv
// Packs a configurable header, a stream of payload words and a metadata field
// into one wide frame: frame = {metadata, payload, header}.
module data_packer #(
  parameter int unsigned FRAME_W = 512,
  parameter int unsigned META_W  = 128,
  parameter int unsigned WORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         header_length,
  input  logic [255:0]       header,
  input  logic [META_W-1:0]  metadata,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame,
  output logic [9:0]         data_size,
  output logic               ovf,
  output logic               cfg_err
);

  localparam int unsigned PAY_TOP = FRAME_W - META_W;
  localparam int unsigned PTR_W   = 10;
  localparam logic [PTR_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

  state_t           state;
  logic [7:0]       hl_q;
  logic [PTR_W-1:0] wr_ptr;

  logic [PAY_TOP-1:0] hdr_mask;
  logic [PAY_TOP-1:0] word_mask;
  logic [PAY_TOP-1:0] word_bits;
  logic [10:0]        bit_pos;
  logic [11:0]        word_end;
  logic [10:0]        ptr_sum;
  logic               word_trunc;

  // Word placement: shifting into a PAY_TOP-wide vector drops any bits that
  // would spill into the metadata field.
  always_comb begin
    hdr_mask   = ~({PAY_TOP{1'b1}} << header_length);
    bit_pos    = 11'(hl_q) + 11'(wr_ptr);
    word_mask  = PAY_TOP'({WORD_W{1'b1}}) << bit_pos;
    word_bits  = PAY_TOP'(in_data) << bit_pos;
    word_end   = 12'(bit_pos) + 12'(WORD_W);
    word_trunc = word_end > 12'(PAY_TOP);
    ptr_sum    = 11'(wr_ptr) + 11'(WORD_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hl_q        <= '0;
      wr_ptr      <= '0;
      frame       <= '0;
      data_size   <= '0;
      ovf         <= 1'b0;
      cfg_err     <= 1'b0;
      frame_valid <= 1'b0;
      in_ready    <= 1'b0;
      cfg_ready   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            if (header_length == 8'd0) begin
              cfg_err <= 1'b1;
            end else begin
              hl_q      <= header_length;
              data_size <= 10'(PAY_TOP) - 10'(header_length);
              frame     <= {metadata, PAY_TOP'(header) & hdr_mask};
              wr_ptr    <= '0;
              ovf       <= 1'b0;
              state     <= FILL;
              cfg_ready <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (in_valid && in_ready) begin
            frame[PAY_TOP-1:0] <= (frame[PAY_TOP-1:0] & ~word_mask) | word_bits;
            if (wr_ptr >= data_size || word_trunc) ovf <= 1'b1;
            wr_ptr <= (ptr_sum > 11'(PTR_MAX)) ? PTR_MAX : PTR_W'(ptr_sum);
            if (in_last) begin
              state       <= OUT;
              in_ready    <= 1'b0;
              frame_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          // cfg_ready comes back only after the frame handshake edge
          if (frame_valid && frame_ready) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
            cfg_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_packer.sv
// Directed-vector bench for data_packer with hand-built expected frames.
module tb_data_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [7:0]   header_length;
  logic [255:0] header;
  logic [127:0] metadata;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         frame_valid;
  logic         frame_ready;
  logic [511:0] frame;
  logic [9:0]   data_size;
  logic         ovf;
  logic         cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  data_packer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .header_length(header_length), .header(header), .metadata(metadata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame(frame),
    .data_size(data_size), .ovf(ovf), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_cfg(input logic [7:0] hl, input logic [255:0] hdr, input logic [127:0] meta);
    header_length = hl;
    header        = hdr;
    metadata      = meta;
    cfg_valid     = 1'b1;
    for (int i = 0; i < 20 && !cfg_ready; i++) step;
    if (!cfg_ready) check("cfg_ready_timeout", 512'(cfg_ready), 512'(1));
    step;
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step;
    if (!in_ready) check("in_ready_timeout", 512'(in_ready), 512'(1));
    step;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_frame;
    for (int i = 0; i < 20 && !frame_valid; i++) step;
    check("frame_valid_rise", 512'(frame_valid), 512'(1));
  endtask

  task automatic drain;
    frame_ready = 1'b1;
    step;
    frame_ready = 1'b0;
  endtask

  logic [31:0]  w [8];
  logic [511:0] exp_frame;
  logic [511:0] held_frame;
  logic [255:0] hdr_v;
  logic [127:0] m1, m2, m3;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; header_length = '0; header = '0; metadata = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; frame_ready = 1'b0;
    m1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    m2 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
    m3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    step; step;

    // reset values
    check("rst_cfg_ready", 512'(cfg_ready), 512'(0));
    check("rst_in_ready", 512'(in_ready), 512'(0));
    check("rst_frame_valid", 512'(frame_valid), 512'(0));
    check("rst_frame", frame, 512'(0));
    check("rst_data_size", 512'(data_size), 512'(0));
    check("rst_ovf", 512'(ovf), 512'(0));
    check("rst_cfg_err", 512'(cfg_err), 512'(0));
    rst_n = 1'b1;
    step;
    check("post_rst_cfg_ready", 512'(cfg_ready), 512'(1));

    // zero header length is rejected
    send_cfg(8'd0, '1, m1);
    check("hl0_cfg_err", 512'(cfg_err), 512'(1));
    check("hl0_cfg_ready", 512'(cfg_ready), 512'(1));
    check("hl0_in_ready", 512'(in_ready), 512'(0));
    step;
    check("hl0_cfg_err_pulse", 512'(cfg_err), 512'(0));
    check("hl0_frame", frame, 512'(0));
    check("hl0_in_ready_later", 512'(in_ready), 512'(0));

    // hl=128, eight words fill the payload exactly
    for (int i = 0; i < 8; i++) w[i] = 32'h1000_0001 + 32'(i) * 32'h0111_1111;
    send_cfg(8'd128, {32{8'hA5}}, m1);
    check("hl128_in_ready", 512'(in_ready), 512'(1));
    check("hl128_cfg_ready", 512'(cfg_ready), 512'(0));
    check("hl128_data_size", 512'(data_size), 512'(256));
    for (int i = 0; i < 8; i++) send_word(w[i], i == 7);
    wait_frame;
    exp_frame = '0;
    exp_frame[511:384] = m1;
    exp_frame[383:128] = {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
    exp_frame[127:0]   = {16{8'hA5}};
    check("hl128_frame", frame, exp_frame);
    check("hl128_ovf", 512'(ovf), 512'(0));
    check("hl128_in_ready_out", 512'(in_ready), 512'(0));

    // back-pressure: frame held, stray payload and cfg ignored
    held_frame = frame;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; cfg_valid = 1'b1; header_length = 8'd8;
    for (int i = 0; i < 5; i++) begin
      step;
      check("hold_frame_valid", 512'(frame_valid), 512'(1));
      check("hold_frame", frame, exp_frame);
    end
    check("hold_data_size", 512'(data_size), 512'(256));
    check("hold_cfg_ready", 512'(cfg_ready), 512'(0));
    in_valid = 1'b0; cfg_valid = 1'b0;
    drain;
    check("hs_frame_valid", 512'(frame_valid), 512'(0));
    check("hs_cfg_ready", 512'(cfg_ready), 512'(1));
    check("hs_frame_kept", frame, held_frame);

    // hl=100, short payload leaves zeros above the last word
    for (int i = 0; i < 3; i++) w[i] = 32'hA000_0000 ^ (32'h0F0F_1234 << i);
    send_cfg(8'd100, '1, m2);
    check("hl100_data_size", 512'(data_size), 512'(284));
    for (int i = 0; i < 3; i++) send_word(w[i], i == 2);
    wait_frame;
    exp_frame = '0;
    exp_frame[511:384] = m2;
    exp_frame[195:100] = {w[2], w[1], w[0]};
    exp_frame[99:0]    = '1;
    check("hl100_frame", frame, exp_frame);
    check("hl100_ovf", 512'(ovf), 512'(0));
    drain;

    // hl=200, payload overflows: word 5 truncated, word 6 discarded
    for (int i = 0; i < 7; i++) w[i] = 32'h5500_0000 + 32'(i) * 32'h0013_5799;
    hdr_v = {8{32'hC3C3_5A5A}};
    send_cfg(8'd200, hdr_v, m3);
    check("hl200_data_size", 512'(data_size), 512'(184));
    for (int i = 0; i < 7; i++) send_word(w[i], i == 6);
    wait_frame;
    exp_frame = '0;
    exp_frame[511:384] = m3;
    exp_frame[383:200] = {w[5][23:0], w[4], w[3], w[2], w[1], w[0]};
    exp_frame[199:0]   = hdr_v[199:0];
    check("hl200_frame", frame, exp_frame);
    check("hl200_meta", 512'(frame[511:384]), 512'(m3));
    check("hl200_ovf", 512'(ovf), 512'(1));
    drain;

    // reset mid-fill abandons the frame; new cfg clears sticky ovf first
    send_cfg(8'd64, '1, m1);
    check("hl64_ovf_cleared", 512'(ovf), 512'(0));
    send_word(32'h1234_5678, 1'b0);
    send_word(32'h9ABC_DEF0, 1'b0);
    rst_n = 1'b0;
    step;
    check("midrst_frame_valid", 512'(frame_valid), 512'(0));
    check("midrst_in_ready", 512'(in_ready), 512'(0));
    check("midrst_cfg_ready", 512'(cfg_ready), 512'(0));
    check("midrst_frame", frame, 512'(0));
    check("midrst_data_size", 512'(data_size), 512'(0));
    check("midrst_ovf", 512'(ovf), 512'(0));
    check("midrst_cfg_err", 512'(cfg_err), 512'(0));
    rst_n = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check("midrst_no_frame", 512'(frame_valid), 512'(0));
    end
    check("midrst_cfg_ready_back", 512'(cfg_ready), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_packer.md
DATA_PACKER -- requirements
Module: data_packer

Interface
REQ-001 SHALL have parameter FRAME_W, default 512, meaning total frame width in bits.
REQ-002 SHALL have parameter META_W, default 128, meaning metadata field width at the top of the frame.
REQ-003 SHALL have parameter WORD_W, default 32, meaning payload input word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): the frame-configuration handshake.
REQ-007 SHALL have port header_length, input, 8 bits: header size in bits.
REQ-008 SHALL have port header, input, 256 bits: header bits, LSB-aligned.
REQ-009 SHALL have port metadata, input, META_W bits: metadata for the frame.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, WORD_W) and in_last (input, 1): the payload word stream.
REQ-011 SHALL have ports frame_valid (output, 1), frame_ready (input, 1) and frame (output, FRAME_W): the assembled frame.
REQ-012 SHALL have port data_size, output, 10 bits: payload capacity in bits of the current frame.
REQ-013 SHALL have port ovf, output, 1 bit: payload overflow flag for the current frame.
REQ-014 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected configuration.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and OUT.
REQ-016 SHALL drive cfg_ready=1 only in IDLE, in_ready=1 only in FILL, and frame_valid=1 only in OUT.
REQ-017 SHALL, on a cfg handshake with header_length=0, pulse cfg_err for 1 cycle, remain in IDLE and leave frame unchanged.
REQ-018 SHALL, on a cfg handshake with header_length>0:
- register header_length, metadata and header masked to bits [header_length-1:0];
- set data_size = (FRAME_W-META_W) - header_length, i.e. 384-header_length by default;
- clear the payload region and wr_ptr, clear ovf, and go to FILL.
REQ-019 SHALL, for each in_valid and in_ready handshake, write in_data LSB-first at frame bit header_length+wr_ptr, then advance wr_ptr by WORD_W.
REQ-020 SHALL discard any word bits landing at or above bit FRAME_W-META_W; payload writes never touch the metadata or header fields.
REQ-021 SHALL set ovf (sticky until the next cfg acceptance) when a word is accepted with wr_ptr >= data_size, or when a word is truncated by REQ-020.
REQ-022 SHALL move FILL -> OUT on the handshake carrying in_last=1; frame_valid asserts the next cycle.
REQ-023 SHALL leave unwritten payload bits 0 when in_last arrives before the payload region is full.
REQ-024 SHALL place the frame fields as follows: frame[FRAME_W-1:FRAME_W-META_W]=metadata, frame[383:header_length]=payload, frame[header_length-1:0]=header.
REQ-025 SHALL hold frame, data_size and ovf stable in OUT while frame_ready=0.
REQ-026 SHALL move OUT -> IDLE on the cycle frame_valid and frame_ready are both 1; cfg_ready rises the following cycle, with no cfg accepted in the same cycle as the frame handshake.
REQ-027 SHALL size wr_ptr at 10 bits and saturate it at 1023; it does not wrap.
REQ-028 SHALL ignore in_valid outside FILL and cfg_valid outside IDLE; no state change results.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, set: state=IDLE, frame=0, data_size=0, wr_ptr=0, ovf=0, cfg_err=0, frame_valid=0, in_ready=0, cfg_ready=0.
REQ-030 SHALL assert cfg_ready on the first cycle after rst_n returns high.
REQ-031 SHALL, on reset during FILL or OUT, abandon the partial frame with no frame_valid emitted.

Verification
REQ-032 SHALL pass this case: cfg with hl=128, header=0xA5 repeated, metadata=M, then 8 words ending in_last -> data_size=256, frame[383:128]=words in order, frame[511:384]=M, ovf=0.
REQ-033 SHALL pass this case: cfg with hl=0 -> cfg_err pulses for 1 cycle, cfg_ready stays 1, in_ready stays 0.
REQ-034 SHALL pass this case: hl=100, 3 words then in_last -> frame[195:100]=data, frame[383:196]=0, ovf=0.
REQ-035 SHALL pass this case: hl=200 (data_size=184), 7 words then in_last -> bits [383:200] hold the first 184 bits, ovf=1, metadata intact.
REQ-036 SHALL pass this case: frame_ready held 0 for 5 cycles in OUT -> frame_valid=1 and frame constant throughout; handshake -> IDLE, cfg_ready=1 next cycle.
REQ-037 SHALL pass this case: rst_n=0 after 2 words in FILL -> all outputs at reset values next cycle, and no frame_valid is emitted.
